alu_seq: RTL and testbench

Parametrised, registered ALU for the processor datapath. It replaces the combinational 16-bit ALU. It adds a start/done handshake, status flags, an illegal-op indication and an optional iterative multiplier. It sits between the register-file read ports and the write-back mux, and the controller drives it.

---
 rtl/alu_seq.sv | 168 ++++++++++++++++
 tb/tb_alu_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with a start/done handshake. Optional shift-add multiplier when ALU_MUL_EN is defined.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for mul.
// Backpressure: start is ignored while busy; nothing downstream can stall the result.
module alu_seq #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  // Single-cycle datapath; mul is not decoded here, so it lands in default when the multiplier is absent.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    shamt   = b[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  alu_res[0] = ($signed(a) < $signed(b));
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SRA:  alu_res = $signed(a) >>> shamt;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1001;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
      cnt      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand  <= a;
              mplier <= b;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              done     <= 1'b1;
              result   <= alu_res;
              zero     <= (alu_res == '0);
              carry    <= alu_c;
              overflow <= alu_v;
              illegal  <= alu_ill;
            end
          end
        end
        MUL: begin
          // One multiplier bit per cycle, LSB first; the last bit folds straight into result.
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) begin
            result   <= acc_nxt;
            zero     <= (acc_nxt == '0);
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            done     <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= start;
      if (start) begin
        result   <= alu_res;
        zero     <= (alu_res == '0);
        carry    <= alu_c;
        overflow <= alu_v;
        illegal  <= alu_ill;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq; mul expectations follow whether ALU_MUL_EN is defined.
module tb_alu_seq;
  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             illegal;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] r, input logic z,
                            input logic c, input logic v, input logic il);
    check({tag, "_done"}, done, 1);
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, zero, z);
    check({tag, "_carry"}, carry, c);
    check({tag, "_ovf"}, overflow, v);
    check({tag, "_illegal"}, illegal, il);
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int extra;

    reset = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, carry, overflow, illegal}, 0);
    reset = 1'b0;
    tick();

    // add with signed overflow, latency 1, one-cycle done
    check("add_pre_done", done, 0);
    issue(4'b0000, 16'h7FFF, 16'h0001);
    expect_out("add", 16'h8000, 0, 0, 1, 0);
    tick();
    check("add_done_drop", done, 0);
    check("add_hold", result, 16'h8000);

    // sub borrow, then slt back-to-back in the done cycle
    start = 1'b1; op = 4'b0001; a = 16'h0003; b = 16'h0005;
    tick();
    expect_out("sub", 16'hFFFE, 0, 1, 0, 0);
    op = 4'b0010; a = 16'hFFFF; b = 16'h0001;
    tick();
    start = 1'b0;
    expect_out("slt", 16'h0001, 0, 0, 0, 0);

    issue(4'b0011, 16'h0001, 16'h0013);
    expect_out("sll", 16'h0008, 0, 0, 0, 0);
    issue(4'b1000, 16'h8000, 16'h0004);
    expect_out("sra", 16'hF800, 0, 0, 0, 0);
    issue(4'b0100, 16'h8000, 16'h0004);
    expect_out("srl", 16'h0800, 0, 0, 0, 0);

    issue(4'b1011, 16'h1234, 16'h5678);
    expect_out("ill_1011", 16'h0000, 1, 0, 0, 1);
    issue(4'b0101, 16'hF0F0, 16'h0FF0);
    expect_out("and_clr", 16'h00F0, 0, 0, 0, 0);
    issue(4'b0110, 16'hF000, 16'h000F);
    expect_out("or", 16'hF00F, 0, 0, 0, 0);
    issue(4'b0111, 16'hAAAA, 16'hAAAA);
    expect_out("xor_zero", 16'h0000, 1, 0, 0, 0);
    issue(4'b0000, 16'hFFFF, 16'h0001);
    expect_out("add_carry", 16'h0000, 1, 1, 0, 0);

`ifdef ALU_MUL_EN
    issue(4'b1001, 16'h0123, 16'h0045);
    busy_cnt = 0; done_at = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      if (busy) busy_cnt++;
      if (done) done_at = k;
      if (k == 3) begin
        start = 1'b1; op = 4'b0000; a = 16'h0001; b = 16'h0001;
      end else begin
        start = 1'b0;
      end
      if (done_at == 0) tick();
    end
    start = 1'b0;
    check("mul_latency", done_at, 17);
    check("mul_busy_cycles", busy_cnt, 16);
    check("mul_busy_at_done", busy, 0);
    expect_out("mul", 16'h4E6F, 0, 0, 0, 0);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) extra++;
    end
    check("mul_no_extra_done", extra, 0);
    check("mul_hold", result, 16'h4E6F);

    // reset during the fifth busy cycle discards the multiply
    issue(4'b1001, 16'h0123, 16'h0045);
    for (int k = 0; k < 4; k++) tick();
    check("mulrst_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mulrst_busy", busy, 0);
    check("mulrst_done", done, 0);
    check("mulrst_result", result, 0);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done) extra++;
    end
    check("mulrst_no_done", extra, 0);
    issue(4'b0000, 16'h0002, 16'h0002);
    expect_out("add_after_rst", 16'h0004, 0, 0, 0, 0);
`else
    issue(4'b1001, 16'h0123, 16'h0045);
    expect_out("mul_ill", 16'h0000, 1, 0, 0, 1);
    check("mul_ill_busy", busy, 0);
    issue(4'b0101, 16'h00FF, 16'h0F0F);
    expect_out("and_clr2", 16'h000F, 0, 0, 0, 0);
`endif

    // reset wins over a coincident start
    start = 1'b1; op = 4'b0000; a = 16'h0005; b = 16'h0005; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    check("rst_vs_start_done", done, 0);
    check("rst_vs_start_result", result, 0);
    tick();
    check("rst_vs_start_late", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
